// File: rtl/alu_divider.sv
// Iterative restoring divider with valid/ready handshakes on operands and results.
// Optional macro DIV_FAST_PATH_EN: trivial divides (B==0, signed MIN/-1, |A|<|B|) skip CALC.
module alu_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  is_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Quotient,
  output logic [DATA_WIDTH-1:0] Remainder,
  output logic                  DivZero,
  output logic                  Overflow,
  output logic                  Zero
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dq_q, dq_d;
  logic [DATA_WIDTH-1:0] div_q, div_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH:0]   prem_q, prem_d;
  logic                  q_neg_q, q_neg_d;
  logic                  r_neg_q, r_neg_d;
  logic                  dz_q, dz_d;
  logic                  ov_q, ov_d;
  logic [DATA_WIDTH-1:0] quot_q, quot_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic                  dz_out_q, dz_out_d;
  logic                  ov_out_q, ov_out_d;

  logic                  a_neg, b_neg, b_zero, ovf_in;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic [DATA_WIDTH:0]   shifted, trial, prem_nxt;
  logic                  q_bit;
  logic [DATA_WIDTH-1:0] dq_nxt, q_fin, r_fin;

  // Operand decode for the accept edge
  always_comb begin
    a_neg  = is_signed & A[DATA_WIDTH-1];
    b_neg  = is_signed & B[DATA_WIDTH-1];
    a_mag  = a_neg ? (~A + 1'b1) : A;
    b_mag  = b_neg ? (~B + 1'b1) : B;
    b_zero = (B == '0);
    ovf_in = is_signed & (A == {1'b1, {(DATA_WIDTH-1){1'b0}}}) & (B == '1);
  end

  // One restoring step: the dividend shifts out of dq while quotient bits shift in
  always_comb begin
    shifted  = {prem_q[DATA_WIDTH-1:0], dq_q[DATA_WIDTH-1]};
    trial    = shifted - {1'b0, div_q};
    q_bit    = ~trial[DATA_WIDTH];
    prem_nxt = q_bit ? trial : shifted;
    dq_nxt   = {dq_q[DATA_WIDTH-2:0], q_bit};
    q_fin    = q_neg_q ? (~dq_nxt + 1'b1) : dq_nxt;
    r_fin    = r_neg_q ? (~prem_nxt[DATA_WIDTH-1:0] + 1'b1) : prem_nxt[DATA_WIDTH-1:0];
    if (dz_q) begin
      q_fin = '1;
      r_fin = a_q;
    end else if (ov_q) begin
      q_fin = a_q;
      r_fin = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dq_q     <= '0;
      div_q    <= '0;
      a_q      <= '0;
      prem_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      ov_q     <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      dz_out_q <= 1'b0;
      ov_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dq_q     <= dq_d;
      div_q    <= div_d;
      a_q      <= a_d;
      prem_q   <= prem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dz_q     <= dz_d;
      ov_q     <= ov_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dz_out_q <= dz_out_d;
      ov_out_q <= ov_out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dq_d     = dq_q;
    div_d    = div_q;
    a_d      = a_q;
    prem_d   = prem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dz_d     = dz_q;
    ov_d     = ov_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dz_out_d = dz_out_q;
    ov_out_d = ov_out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d   = CNT_INIT;
          dq_d    = a_mag;
          div_d   = b_mag;
          a_d     = A;
          prem_d  = '0;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          dz_d    = b_zero;
          ov_d    = ovf_in;
          state_d = CALC;
`ifdef DIV_FAST_PATH_EN
          if (b_zero || ovf_in || (a_mag < b_mag)) begin
            state_d  = DONE;
            quot_d   = b_zero ? '1 : (ovf_in ? A : '0);
            rem_d    = (ovf_in && !b_zero) ? '0 : A;
            dz_out_d = b_zero;
            ov_out_d = ovf_in & ~b_zero;
          end
`endif
        end
      end
      CALC: begin
        dq_d   = dq_nxt;
        prem_d = prem_nxt;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          quot_d   = q_fin;
          rem_d    = r_fin;
          dz_out_d = dz_q;
          ov_out_d = ov_q & ~dz_q;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    Quotient  = quot_q;
    Remainder = rem_q;
    DivZero   = dz_out_q;
    Overflow  = ov_out_q;
    Zero      = (quot_q == '0);
  end

endmodule
